// File: rtl/can_pkg.sv
// Shared CAN bit-level constants and the stuffer/destuffer state encoding.
package can_pkg;

    localparam logic        CAN_RECESSIVE = 1'b1;
    localparam logic        CAN_DOMINANT  = 1'b0;
    localparam int unsigned CAN_MAX_RUN   = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STUFF
    } stuff_state_t;

endpackage

// File: rtl/can_bit_stuffer.sv
// Transmit-side CAN bit stuffer: inserts one complementary bit after MAX_RUN identical bits.
// Optional stuff-bit counter output enabled by CAN_STUFF_COUNT_EN.
module can_bit_stuffer
    import can_pkg::*;
#(
    parameter int unsigned MAX_RUN     = CAN_MAX_RUN
`ifdef CAN_STUFF_COUNT_EN
   ,parameter int unsigned STUFF_CNT_W = 8
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_point,
    input  logic stuff_en,
    input  logic flush,
    input  logic data_in,
    input  logic data_valid,
    output logic data_ready,
    output logic bit_out,
    output logic stuff_flag
`ifdef CAN_STUFF_COUNT_EN
   ,output logic [STUFF_CNT_W-1:0] stuff_count
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_RUN + 1);

    stuff_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, run_nxt;
    logic             last_q, last_d;
    logic             bit_d, flag_d;

    // The serializer is stalled only while the inserted bit is on the bus.
    assign data_ready = (state_q != S_STUFF);

    assign run_nxt = (data_in == last_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);

    // Next-state and output decode; everything holds between tx_point strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        bit_d   = bit_out;
        flag_d  = stuff_flag;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            last_d  = CAN_RECESSIVE;
            bit_d   = CAN_RECESSIVE;
            flag_d  = 1'b0;
        end else if (tx_point) begin
            case (state_q)
                S_IDLE: begin
                    flag_d = 1'b0;
                    if (data_valid) begin
                        bit_d   = data_in;
                        last_d  = data_in;
                        cnt_d   = stuff_en ? CNT_W'(1) : '0;
                        state_d = S_RUN;
                    end else begin
                        bit_d = CAN_RECESSIVE;
                        cnt_d = '0;
                    end
                end
                S_RUN: begin
                    flag_d = 1'b0;
                    if (data_valid) begin
                        bit_d  = data_in;
                        last_d = data_in;
                        if (stuff_en) begin
                            if (run_nxt == CNT_W'(MAX_RUN)) begin
                                cnt_d   = '0;
                                state_d = S_STUFF;
                            end else begin
                                cnt_d = run_nxt;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end else begin
                        // Upstream underrun ends the frame.
                        bit_d   = CAN_RECESSIVE;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_STUFF: begin
                    bit_d   = ~last_q;
                    flag_d  = 1'b1;
                    last_d  = ~last_q;
                    cnt_d   = CNT_W'(1);
                    state_d = S_RUN;
                end
                default: begin
                    bit_d   = CAN_RECESSIVE;
                    flag_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= CAN_RECESSIVE;
            bit_out    <= CAN_RECESSIVE;
            stuff_flag <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            bit_out    <= bit_d;
            stuff_flag <= flag_d;
        end
    end

`ifdef CAN_STUFF_COUNT_EN
    // Saturating count of inserted stuff bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuff_count <= '0;
        end else if (flush) begin
            stuff_count <= '0;
        end else if (tx_point && (state_q == S_STUFF) && (stuff_count != '1)) begin
            stuff_count <= stuff_count + STUFF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Self-checking bench for can_bit_stuffer: directed scenarios plus randomized traffic
// against a bit-history reference model.
module tb_can_bit_stuffer;
    import can_pkg::*;

    localparam int unsigned MAX_RUN = 5;

    logic clk, rst_n, tx_point, stuff_en, flush, data_in, data_valid;
    logic data_ready, bit_out, stuff_flag;
`ifdef CAN_STUFF_COUNT_EN
    logic [7:0] stuff_count;
`endif

    can_bit_stuffer #(.MAX_RUN(MAX_RUN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_point   (tx_point),
        .stuff_en   (stuff_en),
        .flush      (flush),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_out    (bit_out),
        .stuff_flag (stuff_flag)
`ifdef CAN_STUFF_COUNT_EN
       ,.stuff_count(stuff_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic elig;
    } hbit_t;

    int    checks   = 0;
    int    failures = 0;
    hbit_t hist[$];
    logic  pend;
    int    exp_scount;
    int    flag_seen;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A stuff bit is owed when the last MAX_RUN bus bits were all inside the
    // stuffing region (or stuff bits) and all carry the same value.
    function automatic logic window_full();
        int n = hist.size();
        if (n < int'(MAX_RUN)) return 1'b0;
        for (int i = n - int'(MAX_RUN); i < n; i++) begin
            if (!hist[i].elig || hist[i].b != hist[n-1].b) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        pend       = 1'b0;
        exp_scount = 0;
    endtask

    // One bit time: strobe tx_point for one clk, check outputs the clk after.
    task automatic step(input logic v, input logic d, input logic se, input logic fl,
                        output logic consumed);
        logic eb, ef;
        @(posedge clk);
        #1;
        data_valid = v;
        data_in    = d;
        stuff_en   = se;
        flush      = fl;
        tx_point   = 1'b1;
        chk("data_ready", 8'(data_ready), 8'(!pend));
        consumed = 1'b0;
        if (fl) begin
            eb = 1'b1; ef = 1'b0;
            hist.delete();
            pend = 1'b0;
            exp_scount = 0;
        end else if (pend) begin
            eb = ~hist[hist.size()-1].b; ef = 1'b1;
            hist.push_back('{b: eb, elig: 1'b1});
            pend = 1'b0;
            if (exp_scount < 255) exp_scount++;
        end else if (v) begin
            eb = d; ef = 1'b0; consumed = 1'b1;
            hist.push_back('{b: d, elig: se});
            pend = window_full();
        end else begin
            eb = 1'b1; ef = 1'b0;
            hist.delete();
        end
        if (hist.size() > 16) void'(hist.pop_front());
        @(posedge clk);
        #1;
        tx_point = 1'b0;
        flush    = 1'b0;
        chk("bit_out", 8'(bit_out), 8'(eb));
        chk("stuff_flag", 8'(stuff_flag), 8'(ef));
        if (stuff_flag === 1'b1) flag_seen++;
`ifdef CAN_STUFF_COUNT_EN
        chk("stuff_count", stuff_count, 8'(exp_scount));
`endif
        repeat (2) @(posedge clk);
    endtask

    // Feed n bits (index 0 first), holding each until consumed, then drain any owed stuff bit.
    task automatic feed(input logic [15:0] bits, input int n, input logic se);
        int   i = 0;
        logic c;
        while (i < n || pend) begin
            step(i < n, (i < n) ? bits[i] : 1'b0, se, 1'b0, c);
            if (c) i++;
        end
    endtask

    initial begin
        logic c, prev_d, d, v, se, fl;
        int   f0;

        rst_n = 1'b0; tx_point = 1'b0; stuff_en = 1'b1; flush = 1'b0;
        data_in = 1'b0; data_valid = 1'b1;
        model_reset();
        flag_seen = 0;

        // Reset with a valid bit offered and tx_point strobing.
        repeat (2) begin
            @(posedge clk); #1 tx_point = 1'b1;
            @(posedge clk); #1 tx_point = 1'b0;
        end
        chk("rst_bit_out", 8'(bit_out), 8'h01);
        chk("rst_stuff_flag", 8'(stuff_flag), 8'h00);
        chk("rst_data_ready", 8'(data_ready), 8'h01);
`ifdef CAN_STUFF_COUNT_EN
        chk("rst_stuff_count", stuff_count, 8'h00);
`endif
        data_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, c);

        // 1,1,1,1,1,0: one stuff bit 0 before the delayed 6th bit.
        f0 = flag_seen;
        feed(16'b011111, 6, 1'b1);
        chk("s2_flags", 8'(flag_seen - f0), 8'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, c);

        // Ten 0s: stuff bit starts a new run, two stuff bits total.
        f0 = flag_seen;
        feed(16'h0000, 10, 1'b1);
        chk("s3_flags", 8'(flag_seen - f0), 8'd2);
`ifdef CAN_STUFF_COUNT_EN
        chk("s3_stuff_count", stuff_count, 8'd2);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b0, c);

        // Alternating bits never stuff.
        f0 = flag_seen;
        feed(16'b10101010, 8, 1'b1);
        chk("s4_flags", 8'(flag_seen - f0), 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, c);

        // stuff_en drops right after the run completes: stuff bit still goes out.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, c);
        step(1'b1, 1'b1, 1'b0, 1'b0, c);
        chk("s5_stuff_bit", 8'(bit_out), 8'h00);
        chk("s5_stuff_flag", 8'(stuff_flag), 8'h01);
        f0 = flag_seen;
        feed(16'b11111, 5, 1'b0);
        chk("s5_no_stuff", 8'(flag_seen - f0), 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, c);

        // flush together with tx_point while a stuff bit is owed.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, c);
        chk("s6_stalled", 8'(data_ready), 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b1, c);
        chk("s6_ready_after_flush", 8'(data_ready), 8'h01);
        step(1'b0, 1'b0, 1'b1, 1'b0, c);

        // Randomized traffic with runs, underruns, stuff_en gaps and flushes.
        prev_d = 1'b0;
        for (int n = 0; n < 500; n++) begin
            v  = ($urandom_range(0, 19) != 0);
            d  = ($urandom_range(0, 9) < 8) ? prev_d : ~prev_d;
            se = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 59) == 0);
            step(v, d, se, fl, c);
            if (c) prev_d = d;
        end

        // Async reset mid-bit clears outputs immediately.
        step(1'b1, 1'b0, 1'b0, 1'b0, c);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bit_out", 8'(bit_out), 8'h01);
        chk("async_rst_ready", 8'(data_ready), 8'h01);
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
